// File: rtl/spi_result_tx.sv
// SPI-slave (mode 0, MSB first) result transmitter: one-entry holding register
// serialised on MISO during the next chip-select frame; SCLK/CS_N synchronised into clk.
module spi_result_tx #(
  parameter int unsigned          DATA_WIDTH  = 8,
  parameter int unsigned          SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_FILL  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  sclk_in,
  input  logic                  cs_n_in,
  output logic                  miso,
  output logic                  busy,
  output logic                  hold_valid,
  output logic                  done,
  output logic                  aborted,
  output logic                  overrun
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_CS = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  logic [DATA_WIDTH-1:0]  hold_q, hold_d;
  logic                   hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   seen_rise_q, seen_rise_d;
  logic                   miso_q, miso_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   aborted_q, aborted_d;
  logic                   overrun_q, overrun_d;

  logic sck_s, cs_s;
  logic sck_rise, sck_fall, cs_rise, cs_fall;

  // Synchronised pin levels and single-cycle edge strobes
  always_comb begin
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], sclk_in};
    cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], cs_n_in};
    sck_s      = sck_sync_q[SYNC_STAGES-1];
    cs_s       = cs_sync_q[SYNC_STAGES-1];
    sck_prev_d = sck_s;
    cs_prev_d  = cs_s;
    sck_rise   = sck_s & ~sck_prev_q;
    sck_fall   = ~sck_s & sck_prev_q;
    cs_rise    = cs_s & ~cs_prev_q;
    cs_fall    = ~cs_s & cs_prev_q;
  end

  // Next-state, holding register and pulse generation
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    seen_rise_d  = seen_rise_q;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    overrun_d    = 1'b0;

    if (load) begin
      hold_d       = data_in;
      hold_valid_d = 1'b1;
      overrun_d    = hold_valid_q;
    end

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d      = SHIFT;
          bit_cnt_d    = '0;
          seen_rise_d  = 1'b0;
          hold_valid_d = 1'b0;
          // A load coinciding with frame start bypasses the holding register
          if (load)              shift_d = data_in;
          else if (hold_valid_q) shift_d = hold_q;
          else                   shift_d = IDLE_FILL;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else if (sck_rise) begin
          seen_rise_d = 1'b1;
          bit_cnt_d   = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            done_d  = 1'b1;
            state_d = WAIT_CS;
          end
        end else if (sck_fall && seen_rise_q) begin
          shift_d = shift_q << 1;
        end
      end
      WAIT_CS: begin
        if (cs_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    miso_d = (state_d == SHIFT) ? shift_d[DATA_WIDTH-1] : 1'b0;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sck_sync_q   <= '1;
      cs_sync_q    <= '1;
      sck_prev_q   <= 1'b1;
      cs_prev_q    <= 1'b1;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      seen_rise_q  <= 1'b0;
      miso_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sck_sync_q   <= sck_sync_d;
      cs_sync_q    <= cs_sync_d;
      sck_prev_q   <= sck_prev_d;
      cs_prev_q    <= cs_prev_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      seen_rise_q  <= seen_rise_d;
      miso_q       <= miso_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      overrun_q    <= overrun_d;
    end
  end

  assign miso       = miso_q;
  assign busy       = busy_q;
  assign hold_valid = hold_valid_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_spi_result_tx.sv
// Randomised bench for spi_result_tx: an SPI master drives frames, a scoreboard
// queue holds expected frame outcomes, and a monitor checks done/aborted pulses.
module tb_spi_result_tx;

  localparam int unsigned DW   = 8;
  localparam int unsigned SYNC = 2;
  localparam int unsigned HALF = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          load;
  logic [DW-1:0] data_in;
  logic          sclk_in;
  logic          cs_n_in;
  logic          miso, busy, hold_valid, done, aborted, overrun;

  spi_result_tx #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC), .IDLE_FILL(8'h00)) dut (
    .clk(clk), .reset(reset), .load(load), .data_in(data_in),
    .sclk_in(sclk_in), .cs_n_in(cs_n_in), .miso(miso), .busy(busy),
    .hold_valid(hold_valid), .done(done), .aborted(aborted), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_done;
    logic [DW-1:0] b;
    int            nbits;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ovr_exp = 0;
  int   ovr_seen = 0;

  // Reference model of the holding register
  bit            model_hv = 1'b0;
  logic [DW-1:0] model_hold = '0;

  // Bits the master actually sampled in the current frame
  logic [DW-1:0] cap = '0;
  int            cap_n = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Monitor: every done/aborted pulse must match the oldest expected outcome
  always @(negedge clk) begin
    if (!reset) begin
      if (overrun) ovr_seen++;
      if (done || aborted) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {30'd0, done, aborted}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("frame_kind", {31'd0, done}, {31'd0, e.is_done});
          chk("pulse_exclusive", {31'd0, done & aborted}, 32'd0);
          chk("bits_sampled", 32'(cap_n), 32'(e.nbits));
          if (e.is_done) chk("frame_data", {24'd0, cap}, {24'd0, e.b});
          else           chk("abort_partial", {24'd0, cap}, {24'd0, e.b >> (DW - e.nbits)});
        end
      end
    end
  end

  task automatic do_load(input logic [DW-1:0] d);
    @(negedge clk);
    load = 1'b1; data_in = d;
    if (model_hv) ovr_exp++;
    model_hold = d; model_hv = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("hold_valid_after_load", {31'd0, hold_valid}, 32'd1);
  endtask

  task automatic sclk_cycle(input bit sample);
    sclk_in = 1'b1;
    if (sample) begin
      cap = {cap[DW-2:0], miso};
      cap_n++;
    end
    repeat (HALF) @(negedge clk);
    sclk_in = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  // mode: 0 = full frame, 1 = abort after k clocks, 2 = cs rise with final sclk rise
  task automatic frame(input int mode, input int k, input bit sim_load, input logic [DW-1:0] ld);
    logic [DW-1:0] b;
    exp_t e;
    @(negedge clk);
    cap = '0; cap_n = 0;
    cs_n_in = 1'b0;
    if (sim_load) begin
      if (model_hv) ovr_exp++;
      b = ld;
    end else begin
      b = model_hv ? model_hold : 8'h00;
    end
    model_hv = 1'b0;
    e.is_done = (mode == 0);
    e.b       = b;
    e.nbits   = (mode == 0) ? DW : (mode == 2) ? DW - 1 : k;
    exp_q.push_back(e);
    if (sim_load) begin
      repeat (SYNC) @(negedge clk);
      load = 1'b1; data_in = ld;
      @(negedge clk);
      load = 1'b0;
      repeat (HALF) @(negedge clk);
    end else begin
      repeat (HALF + 2) @(negedge clk);
    end
    chk("busy_in_frame", {31'd0, busy}, 32'd1);
    chk("hold_cleared_at_start", {31'd0, hold_valid}, 32'd0);
    for (int i = 0; i < e.nbits; i++) sclk_cycle(1'b1);
    if (mode == 2) begin
      sclk_in = 1'b1; cs_n_in = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk_in = 1'b0;
    end else begin
      if (mode == 0) chk("miso_wait_cs", {31'd0, miso}, 32'd0);
      cs_n_in = 1'b1;
    end
    repeat (HALF + 2) @(negedge clk);
    chk("busy_after_frame", {31'd0, busy}, 32'd0);
    chk("miso_idle", {31'd0, miso}, 32'd0);
  endtask

  // Reset asserted after four bits of a frame; the frame produces no pulse
  task automatic reset_mid_frame();
    @(negedge clk);
    cap = '0; cap_n = 0;
    cs_n_in = 1'b0;
    model_hv = 1'b0;
    repeat (HALF + 2) @(negedge clk);
    for (int i = 0; i < 4; i++) sclk_cycle(1'b1);
    reset = 1'b1; cs_n_in = 1'b1; sclk_in = 1'b0;
    @(negedge clk);
    chk("rst_miso", {31'd0, miso}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hold_valid", {31'd0, hold_valid}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; data_in = '0; sclk_in = 1'b0; cs_n_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", {26'd0, miso, busy, hold_valid, done, aborted, overrun}, 32'd0);
    reset = 1'b0;
    repeat (6) @(negedge clk);

    do_load(8'hA5);
    frame(0, 0, 1'b0, 8'h00);
    frame(0, 0, 1'b0, 8'h00);
    do_load(8'h3C);
    do_load(8'hC3);
    frame(0, 0, 1'b0, 8'h00);
    do_load(8'hFF);
    frame(1, 3, 1'b0, 8'h00);
    chk("hold_after_abort", {31'd0, hold_valid}, 32'd0);
    frame(0, 0, 1'b1, 8'h81);
    chk("hold_after_bypass", {31'd0, hold_valid}, 32'd0);
    do_load(8'hF0);
    reset_mid_frame();
    frame(0, 0, 1'b0, 8'h00);
    do_load(8'h5A);
    frame(2, 0, 1'b0, 8'h00);

    for (int it = 0; it < 30; it++) begin
      int nl, m;
      nl = int'($urandom_range(0, 2));
      for (int j = 0; j < nl; j++) do_load(DW'($urandom));
      m = int'($urandom_range(0, 9));
      if (m <= 5)      frame(0, 0, 1'b0, 8'h00);
      else if (m <= 7) frame(1, int'($urandom_range(0, DW - 1)), 1'b0, 8'h00);
      else if (m == 8) frame(2, 0, 1'b0, 8'h00);
      else             frame(0, 0, 1'b1, DW'($urandom));
    end

    for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("overrun_count", 32'(ovr_seen), 32'(ovr_exp));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
